// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: opcode encodings, flag bit
// positions, FSM states and the shift-magnitude helper.
package alu_pkg;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_SUBC = 8'h0A;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;
    localparam logic [3:0] OP_LUI_HI = 4'hF;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    // Magnitude of a signed 5-bit shift amount; -16 maps to 16.
    function automatic logic [4:0] shift_mag(input logic [4:0] amt);
        return amt[4] ? (5'd0 - amt) : amt;
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shifter for LSH/ASHU: iterative one-bit-per-cycle shift register by default,
// single-cycle barrel shifter when ALU_BARREL_SHIFT_EN is defined.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
`ifndef ALU_BARREL_SHIFT_EN
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
`endif
    input  logic             ashu_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [4:0]       amt_i,
`ifndef ALU_BARREL_SHIFT_EN
    output logic [WIDTH-1:0] next_o,
    output logic [4:0]       cnt_o
`else
    output logic [WIDTH-1:0] result_o
`endif
);

`ifndef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] sreg_q, sreg_d, next_s;
    logic [4:0]       cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;

    // One-bit step; right shifts replicate the sign only for arithmetic mode.
    always_comb begin
        next_s = sreg_q;
        if (left_q) begin
            next_s = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            next_s = {arith_q & sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
        end
    end

    // Load operand and count on accept, otherwise advance one bit per step.
    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load_i) begin
            sreg_d  = a_i;
            cnt_d   = shift_mag(amt_i);
            left_d  = ~amt_i[4];
            arith_d = ashu_i;
        end else if (step_i) begin
            sreg_d = next_s;
            cnt_d  = cnt_q - 5'd1;
        end else begin
            sreg_d = sreg_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sreg_q  <= '0;
            cnt_q   <= 5'd0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign next_o = next_s;
    assign cnt_o  = cnt_q;
`else
    logic [4:0] mag_s;

    // Full shift in one cycle.
    always_comb begin
        mag_s = shift_mag(amt_i);
        if (!amt_i[4]) begin
            result_o = a_i << mag_s;
        end else if (ashu_i) begin
            result_o = $signed(a_i) >>> mag_s;
        end else begin
            result_o = a_i >> mag_s;
        end
    end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with start/busy/done handshake and persistent flags.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts (busy tied low).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       aluOpcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   add_s, sub_s;
    logic             add_ovf_s, sub_ovf_s;
    logic [WIDTH-1:0] ex_result_s;
    logic [4:0]       ex_flags_s;
    logic             ex_keep_s;
    logic             is_shift_s;

`ifndef ALU_BARREL_SHIFT_EN
    alu_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             ex_iter_s;
    logic             shift_load_s, shift_step_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [4:0]       shift_cnt_s;

    alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .clock  (clock),
        .reset  (reset),
        .load_i (shift_load_s),
        .step_i (shift_step_s),
        .ashu_i (aluOpcode == OP_ASHU),
        .a_i    (a),
        .amt_i  (b[4:0]),
        .next_o (shift_next_s),
        .cnt_o  (shift_cnt_s)
    );
`else
    logic [WIDTH-1:0] shift_res_s;

    alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .ashu_i   (aluOpcode == OP_ASHU),
        .a_i      (a),
        .amt_i    (b[4:0]),
        .result_o (shift_res_s)
    );
`endif

    // Borrow/carry-in come from the current C flag only for ADDC/SUBC.
    always_comb begin
        add_s = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, (aluOpcode == OP_ADDC) & flags_q[FLAG_C]};
        sub_s = {1'b0, a} - {1'b0, b}
              - {{WIDTH{1'b0}}, (aluOpcode == OP_SUBC) & flags_q[FLAG_C]};
        add_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
        sub_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
    end

    // Opcode decode: single-cycle result and the flag update it implies.
    always_comb begin
        ex_result_s = '0;
        ex_flags_s  = flags_q;
        ex_keep_s   = 1'b0;
        is_shift_s  = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
        ex_iter_s   = 1'b0;
`endif
        case (aluOpcode)
            OP_AND:  ex_result_s = a & b;
            OP_OR:   ex_result_s = a | b;
            OP_XOR:  ex_result_s = a ^ b;
            OP_MOV:  ex_result_s = b;
            OP_ADDU: ex_result_s = add_s[WIDTH-1:0];
            OP_ADD, OP_ADDC: begin
                ex_result_s        = add_s[WIDTH-1:0];
                ex_flags_s[FLAG_C] = add_s[WIDTH];
                ex_flags_s[FLAG_F] = add_ovf_s;
            end
            OP_SUB, OP_SUBC: begin
                ex_result_s        = sub_s[WIDTH-1:0];
                ex_flags_s[FLAG_C] = sub_s[WIDTH];
                ex_flags_s[FLAG_F] = sub_ovf_s;
            end
            OP_CMP: begin
                ex_keep_s          = 1'b1;
                ex_flags_s[FLAG_Z] = (a == b);
                ex_flags_s[FLAG_N] = ($signed(a) < $signed(b));
                ex_flags_s[FLAG_L] = (a < b);
            end
            OP_LSH, OP_ASHU: is_shift_s = 1'b1;
            default: begin
                if (aluOpcode[7:4] == OP_LUI_HI) begin
                    ex_result_s[15:0] = {b[7:0], 8'h00};
                end else begin
                    ex_result_s = '0;
                end
            end
        endcase
        if (is_shift_s) begin
`ifndef ALU_BARREL_SHIFT_EN
            if (b[4:0] == 5'd0) begin
                ex_result_s = a;
            end else begin
                ex_iter_s = 1'b1;
                ex_keep_s = 1'b1;
            end
`else
            ex_result_s = shift_res_s;
`endif
        end else begin
            ex_keep_s = ex_keep_s;
        end
    end

    // Handshake control: accept in IDLE, finish an iterative shift in SHIFT.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
        state_d      = state_q;
        busy_d       = busy_q;
        shift_load_s = 1'b0;
        shift_step_s = 1'b0;
        if (state_q == ST_SHIFT) begin
            shift_step_s = 1'b1;
            if (shift_cnt_s == 5'd1) begin
                result_d = shift_next_s;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end else begin
                busy_d = 1'b1;
            end
        end else
`endif
        if (start) begin
            done_d  = 1'b1;
            flags_d = ex_flags_s;
            if (!ex_keep_s) begin
                result_d = ex_result_s;
            end else begin
                result_d = result_q;
            end
`ifndef ALU_BARREL_SHIFT_EN
            if (ex_iter_s) begin
                done_d       = 1'b0;
                shift_load_s = 1'b1;
                busy_d       = 1'b1;
                state_d      = ST_SHIFT;
            end else begin
                busy_d = 1'b0;
            end
`endif
        end else begin
            done_d = 1'b0;
        end
    end

    // Output and flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            flags_q  <= 5'd0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

`ifndef ALU_BARREL_SHIFT_EN
    // FSM state and busy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (iterative shifter build): directed
// vector table, handshake corner sequences and random ops vs. a reference model.
module tb_alu_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  aluOpcode;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_result;
    logic [4:0]  m_flags;   // {C, L, F, Z, N}

    typedef struct {
        logic [7:0]  op;
        logic [15:0] av;
        logic [15:0] bv;
        logic [15:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    vec_t tbl [23];
    logic [7:0] ops [12] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07,
                             8'h09, 8'h0A, 8'h0B, 8'h0D, 8'h84, 8'h86};

    alu_exec_unit #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .aluOpcode (aluOpcode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: spec rules in plain integer arithmetic.
    task automatic model_exec(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv,
                              output int lat);
        int sa, sb, s, k, cin;
        sa  = $signed(av);
        sb  = $signed(bv);
        lat = 0;
        case (op)
            8'h01: m_result = av & bv;
            8'h02: m_result = av | bv;
            8'h03: m_result = av ^ bv;
            8'h0D: m_result = bv;
            8'h06: m_result = av + bv;
            8'h05, 8'h07: begin
                cin = (op == 8'h07) ? int'(m_flags[4]) : 0;
                s = int'(av) + int'(bv) + cin;
                m_result   = s[15:0];
                m_flags[4] = (s > 65535);
                m_flags[2] = ((sa + sb + cin) > 32767) || ((sa + sb + cin) < -32768);
            end
            8'h09, 8'h0A: begin
                cin = (op == 8'h0A) ? int'(m_flags[4]) : 0;
                s = int'(av) - int'(bv) - cin;
                m_result   = s[15:0];
                m_flags[4] = (s < 0);
                m_flags[2] = ((sa - sb - cin) > 32767) || ((sa - sb - cin) < -32768);
            end
            8'h0B: begin
                m_flags[1] = (av == bv);
                m_flags[0] = (sa < sb);
                m_flags[3] = (av < bv);
            end
            8'h84, 8'h86: begin
                k = $signed(bv[4:0]);
                if (k >= 0) begin
                    lat = k;
                    m_result = av << k;
                end else begin
                    lat = -k;
                    if (op == 8'h84) begin
                        m_result = av >> (-k);
                    end else begin
                        s = sa >>> (-k);
                        m_result = s[15:0];
                    end
                end
            end
            default: m_result = (op[7:4] == 4'hF) ? {bv[7:0], 8'h00} : 16'h0000;
        endcase
    endtask

    // Issue one op and check busy/done timing plus final result/flags.
    task automatic run_op(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] er, input logic [4:0] ef, input int elat,
                          input string tag);
        @(negedge clock);
        start = 1'b1; aluOpcode = op; a = av; b = bv;
        @(posedge clock); #1;
        start = 1'b0; aluOpcode = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
        for (int i = 0; i < elat; i++) begin
            chk($sformatf("%s busy/done c%0d", tag, i), {30'd0, busy, done}, 32'd2);
            @(posedge clock); #1;
        end
        chk($sformatf("%s busy/done end", tag), {30'd0, busy, done}, 32'd1);
        chk($sformatf("%s result", tag), {16'd0, result}, {16'd0, er});
        chk($sformatf("%s flags", tag), {27'd0, flags}, {27'd0, ef});
    endtask

    initial begin
        int lat, dcount;
        logic [15:0] dres;
        logic [7:0] op;
        logic [15:0] ra, rb;

        tbl[0]  = '{8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 0};
        tbl[1]  = '{8'h05, 16'hFFFF, 16'h0001, 16'h0000, 5'b10000, 0};
        tbl[2]  = '{8'h07, 16'h0000, 16'h0000, 16'h0001, 5'b00000, 0};
        tbl[3]  = '{8'h0B, 16'h0001, 16'hFFFF, 16'h0001, 5'b01000, 0};
        tbl[4]  = '{8'h01, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b01000, 0};
        tbl[5]  = '{8'h02, 16'hF0F0, 16'h0F01, 16'hFFF1, 5'b01000, 0};
        tbl[6]  = '{8'h03, 16'hAAAA, 16'hFFFF, 16'h5555, 5'b01000, 0};
        tbl[7]  = '{8'h0D, 16'h1234, 16'hBEEF, 16'hBEEF, 5'b01000, 0};
        tbl[8]  = '{8'hF7, 16'h0000, 16'h12AB, 16'hAB00, 5'b01000, 0};
        tbl[9]  = '{8'h84, 16'h8001, 16'h001D, 16'h1000, 5'b01000, 3};
        tbl[10] = '{8'h86, 16'h8001, 16'h001D, 16'hF000, 5'b01000, 3};
        tbl[11] = '{8'h84, 16'h0001, 16'h000F, 16'h8000, 5'b01000, 15};
        tbl[12] = '{8'h86, 16'h8000, 16'h0010, 16'hFFFF, 5'b01000, 16};
        tbl[13] = '{8'h84, 16'h8000, 16'h0010, 16'h0000, 5'b01000, 16};
        tbl[14] = '{8'h84, 16'h1234, 16'h0020, 16'h1234, 5'b01000, 0};
        tbl[15] = '{8'h04, 16'h1111, 16'h2222, 16'h0000, 5'b01000, 0};
        tbl[16] = '{8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'b11000, 0};
        tbl[17] = '{8'h0A, 16'h0005, 16'h0002, 16'h0002, 5'b01000, 0};
        tbl[18] = '{8'h09, 16'h8000, 16'h0001, 16'h7FFF, 5'b01100, 0};
        tbl[19] = '{8'h0B, 16'h0005, 16'h0005, 16'h7FFF, 5'b00110, 0};
        tbl[20] = '{8'h0B, 16'hFFFF, 16'h0001, 16'h7FFF, 5'b00101, 0};
        tbl[21] = '{8'h06, 16'hFFFF, 16'h0002, 16'h0001, 5'b00101, 0};
        tbl[22] = '{8'h07, 16'h0001, 16'h0001, 16'h0002, 5'b00001, 0};

        reset = 1'b0; start = 1'b0; aluOpcode = 8'h00; a = 16'h0000; b = 16'h0000;
        m_result = 16'h0000; m_flags = 5'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset outputs", {9'd0, busy, done, result, flags}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed vectors, issued back to back.
        for (int i = 0; i < 23; i++) begin
            model_exec(tbl[i].op, tbl[i].av, tbl[i].bv, lat);
            run_op(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].res, tbl[i].flg, tbl[i].lat,
                   $sformatf("vec%0d", i));
        end
        @(posedge clock); #1;
        chk("done single pulse", {31'd0, done}, 32'd0);

        // start during busy is ignored: exactly one done, with the shift result.
        model_exec(8'h84, 16'h8001, 16'h001D, lat);
        @(negedge clock);
        start = 1'b1; aluOpcode = 8'h84; a = 16'h8001; b = 16'h001D;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        start = 1'b1; aluOpcode = 8'h05; a = 16'h0001; b = 16'h0001;
        @(posedge clock); #1;
        start = 1'b0;
        dcount = 0; dres = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                dcount++;
                dres = result;
            end
            @(posedge clock); #1;
        end
        chk("busy start dones", dcount, 32'd1);
        chk("busy start result", {16'd0, dres}, {16'd0, m_result});
        chk("busy start flags", {27'd0, flags}, {27'd0, m_flags});

        // Reset during shift cycle 2 aborts with no done.
        @(negedge clock);
        start = 1'b1; aluOpcode = 8'h84; a = 16'h00FF; b = 16'h0005;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("mid-shift busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid-shift reset outputs", {9'd0, busy, done, result, flags}, 32'd0);
        m_result = 16'h0000; m_flags = 5'd0;
        @(negedge clock);
        reset = 1'b1;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (done || busy) dcount++;
        end
        chk("after reset idle", dcount, 32'd0);
        model_exec(8'h05, 16'h0003, 16'h0004, lat);
        run_op(8'h05, 16'h0003, 16'h0004, m_result, m_flags, lat, "post-reset add");

        // Random ops against the reference model.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) op = 8'($urandom);
            else op = ops[$urandom_range(0, 11)];
            ra = 16'($urandom);
            rb = 16'($urandom);
            model_exec(op, ra, rb, lat);
            run_op(op, ra, rb, m_result, m_flags, lat, $sformatf("rnd%0d op%h", i, op));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
